ex_forward_ctrl: RTL and testbench
==================================

# ex_forward_ctrl

Forwarding and hazard controller for the EX-stage operand muxes of the 5-stage MIPS pipeline. It keeps a shadow copy of the destination-register state of the instructions in EX, MEM and WB. From that state it produces registered 2-bit select codes for the operand-A and operand-B 3:1 muxes: 00 = register file, 01 = MEM/WB writeback data, 10 = EX/MEM ALU result, 11 = unused/zero. It also raises a one-cycle load-use stall, honours branch flushes and counts stall cycles for performance monitoring.

## Interface
Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_W  source register A of the ID instruction
- id_rt  in  REG_W  source register B of the ID instruction
- id_uses_rs  in  1  the ID instruction reads rs
- id_uses_rt  in  1  the ID instruction reads rt
- id_dest  in  REG_W  destination register of the ID instruction, already resolved rd/rt
- id_reg_write  in  1  the ID instruction writes the register file
- id_mem_read  in  1  the ID instruction is a load
- flush  in  1  branch/jump taken; kill the ID instruction this cycle
- stall  out  1  combinational; hold PC and IF/ID, insert a bubble into EX
- fwd_a_sel  out  2  registered; operand-A mux select for the instruction now in EX
- fwd_b_sel  out  2  registered; operand-B mux select for the instruction now in EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Shadow stages: ex_q, mem_q and wb_q. Each stage holds {valid, dest, reg_write, mem_read}.
- Every cycle the stages advance: mem_q→wb_q, ex_q→mem_q, and the ID info or a bubble→ex_q.
- Bubble: valid=0, reg_write=0, mem_read=0, dest=0. A bubble enters ex_q when any of these holds: id_valid=0, stall=1, or flush=1.
- A stage "hits" a source register r when all of these hold: stage valid, reg_write=1, dest==r, and r!=0. Register $0 is never forwarded.
- Select for a source r used by the ID instruction, evaluated in priority order:
  - 10 if ex_q hits r (that instruction moves to MEM as the ID instruction enters EX).
  - else 01 if mem_q hits r (that instruction moves to WB).
  - else 00.
  - If the source is not used (id_uses_x=0), the select is 00.
- Older writers in wb_q are covered by the register file's write-before-read behaviour. They produce no forwarding.
- Load-use: stall=1 when all of these hold: id_valid, ex_q.valid, ex_q.mem_read, and ex_q.dest matches a used, nonzero id_rs or id_rt. Stall is never asserted while flush=1.
- On the cycle after a stall, ID is re-evaluated with the load now in mem_q. The select becomes 01.
- fwd_a_sel / fwd_b_sel registers load the computed selects when ID advances (stall=0, flush=0, id_valid=1). Otherwise they load 00.
- stall_cnt increments by 1 on each cycle with stall=1 and saturates at all-ones.

## Timing
- Reset (reset_n=0 at a rising edge): all shadow stages become bubbles, fwd_a_sel=00, fwd_b_sel=00, stall_cnt=0. With the shadow state empty, stall is 0 in the next cycle.
- Reset asserted mid-stall: the stall drops the cycle after the reset edge, because all shadow stages are cleared.
- Select latency: computed combinationally in cycle N from ID inputs. Valid at the mux from N+1, the cycle the instruction is in EX, for exactly one cycle.
- Stall latency: combinational in the same cycle as the hazard. It lasts exactly 1 cycle per load-use hazard. Back-to-back loads feeding each other produce 1 stall each.
- Flush and hazard in the same cycle: flush wins. stall=0, a bubble enters EX, selects=00, and the counter does not increment.
- Both sources hit different stages: each select is resolved independently, e.g. A=10 and B=01 is legal.
- Counter wrap: stall_cnt never wraps. It holds all-ones until reset.

## Test plan
- After reset, with `add $3,$1,$2` in ID and no older writers: stall=0 and next cycle fwd_a_sel=00, fwd_b_sel=00, stall_cnt=0.
- `add $5,…` followed immediately by `sub $6,$5,$5` → in sub's EX cycle, fwd_a_sel=10 and fwd_b_sel=10.
- `add $5,…`, then a nop, then `or $7,$1,$5` → fwd_a_sel=00, fwd_b_sel=01.
- `lw $4,0($1)` followed by `add $8,$4,$2` → stall=1 for exactly 1 cycle and stall_cnt=1; then in add's EX cycle fwd_a_sel=01.
- Writer to $0 followed by a reader of $0 → selects 00 and no stall. A load-use hazard coincident with flush=1 → stall=0, EX receives a bubble, and the counter is unchanged.
- Force 2^CNT_W+3 load-use stalls → stall_cnt holds 0xFFFF. Pulling reset_n low during a stall clears everything next cycle.

Source files
------------

// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl
//   Forwarding and load-use hazard controller for the EX-stage operand muxes
//   of a 5-stage MIPS pipeline. It keeps a shadow of the destination state of
//   the instructions in EX and MEM. From that state it produces registered
//   operand-mux selects for the instruction entering EX, a combinational
//   load-use stall, and a saturating stall-cycle counter.
//
//   Select encoding: 00 register file, 01 MEM/WB writeback data,
//                    10 EX/MEM ALU result, 11 unused.
//
// Ports
//   clk           pipeline clock, rising-edge
//   reset_n       synchronous active-low reset
//   id_valid      ID stage holds a real instruction
//   id_rs/id_rt   source registers of the ID instruction
//   id_uses_rs/rt ID instruction reads rs / rt
//   id_dest       resolved destination register of the ID instruction
//   id_reg_write  ID instruction writes the register file
//   id_mem_read   ID instruction is a load
//   flush         taken branch/jump: kill the ID instruction this cycle
//   stall         combinational load-use stall (hold PC/IFID, bubble EX)
//   fwd_a_sel     registered operand-A select for the instruction in EX
//   fwd_b_sel     registered operand-B select for the instruction in EX
//   stall_cnt     saturating count of stall cycles
module ex_forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } stage_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  // The instruction leaving MEM is not tracked: by the time a reader needs
  // it, the register file's write-before-read already supplies the value.
  stage_t           ex_q, ex_d;
  stage_t           mem_q;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             advance;

  // A stage supplies register r when it will write r; $0 is never forwarded.
  function automatic logic hits(input stage_t s, input logic [REG_W-1:0] r);
    return s.valid && s.reg_write && (s.dest == r) && (r != '0);
  endfunction

  // EX is the younger writer, so its result takes priority over MEM.
  function automatic logic [1:0] sel_for(input logic             used,
                                         input logic [REG_W-1:0] r,
                                         input stage_t           ex,
                                         input stage_t           mem);
    logic [1:0] sel;
    sel = SEL_RF;
    if (used) begin
      if (hits(ex, r))       sel = SEL_ALU;
      else if (hits(mem, r)) sel = SEL_WB;
    end
    return sel;
  endfunction

  // A load in EX cannot forward its data yet; the dependent reader must wait.
  function automatic logic load_use(input stage_t           ex,
                                    input logic             used,
                                    input logic [REG_W-1:0] r);
    return ex.valid && ex.mem_read && used && (r != '0) && (ex.dest == r);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&c) ? c : c + one;
  endfunction

  always_comb begin
    stall   = 1'b0;
    advance = 1'b0;
    ex_d    = '0;
    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    cnt_d   = cnt_q;

    // Flush kills the ID instruction, so a hazard it carries is irrelevant.
    stall   = id_valid && !flush &&
              (load_use(ex_q, id_uses_rs, id_rs) ||
               load_use(ex_q, id_uses_rt, id_rt));
    advance = id_valid && !stall && !flush;

    if (advance) begin
      ex_d.valid     = 1'b1;
      ex_d.dest      = id_dest;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      fwd_a_d        = sel_for(id_uses_rs, id_rs, ex_q, mem_q);
      fwd_b_d        = sel_for(id_uses_rt, id_rt, ex_q, mem_q);
    end

    if (stall) cnt_d = sat_inc(cnt_q);
  end

  // ID -> EX -> MEM shadow advance, select and counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Testbench for ex_forward_ctrl. A table of per-cycle ID inputs with the
// expected combinational stall (sampled before the edge) and the expected
// registered selects and stall count (sampled after the edge), followed by a
// hand-written counter-saturation sequence and a final reset check.
// The counter is instantiated narrow so that saturation is reached quickly.
module tb_ex_forward_ctrl;

  localparam int REG_W = 5;
  localparam int CW    = 8;
  localparam int NVEC  = 20;
  localparam int NSAT  = (1 << CW) + 3;

  logic             clk;
  logic             reset_n;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CW-1:0]    stall_cnt;

  int checks   = 0;
  int failures = 0;

  ex_forward_ctrl #(.REG_W(REG_W), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic             v;
    logic [REG_W-1:0] rs;
    logic             urs;
    logic [REG_W-1:0] rt;
    logic             urt;
    logic [REG_W-1:0] dest;
    logic             rw;
    logic             mr;
    logic             fl;
    logic             es;
    logic [1:0]       ea;
    logic [1:0]       eb;
    logic [CW-1:0]    ec;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic rst_n, input logic v,
                              input int rs, input logic urs,
                              input int rt, input logic urt,
                              input int dest, input logic rw, input logic mr,
                              input logic fl, input logic es,
                              input logic [1:0] ea, input logic [1:0] eb,
                              input int ec);
    vec_t t;
    t.rst_n = rst_n; t.v = v;
    t.rs = REG_W'(rs); t.urs = urs; t.rt = REG_W'(rt); t.urt = urt;
    t.dest = REG_W'(dest); t.rw = rw; t.mr = mr; t.fl = fl;
    t.es = es; t.ea = ea; t.eb = eb; t.ec = CW'(ec);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset_n      = t.rst_n;
    id_valid     = t.v;
    id_rs        = t.rs;
    id_uses_rs   = t.urs;
    id_rt        = t.rt;
    id_uses_rt   = t.urt;
    id_dest      = t.dest;
    id_reg_write = t.rw;
    id_mem_read  = t.mr;
    flush        = t.fl;
  endtask

  initial begin
    int   nstall;
    logic prev_stall;
    int   consec;
    vec_t t;

    //            rst v  rs urs rt urt dst rw mr fl  es  ea     eb     cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0); // reset
    tbl[1]  = mk(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0); // add $3,$1,$2
    tbl[2]  = mk(1, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0); // add $5,$1,$2
    tbl[3]  = mk(1, 1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 2'b10, 2'b10, 0); // sub $6,$5,$5
    tbl[4]  = mk(1, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0); // add $5,$1,$2
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0); // nop
    tbl[6]  = mk(1, 1, 1, 1, 5, 1, 7, 1, 0, 0, 0, 2'b00, 2'b01, 0); // or $7,$1,$5
    tbl[7]  = mk(1, 1, 1, 1, 4, 0, 4, 1, 1, 0, 0, 2'b00, 2'b00, 0); // lw $4,0($1)
    tbl[8]  = mk(1, 1, 4, 1, 2, 1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 1); // add $8,$4,$2 stalls
    tbl[9]  = mk(1, 1, 4, 1, 2, 1, 8, 1, 0, 0, 0, 2'b01, 2'b00, 1); // add re-issued
    tbl[10] = mk(1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1); // lw $0,0($1)
    tbl[11] = mk(1, 1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 1); // add $9,$0,$0
    tbl[12] = mk(1, 1, 1, 1, 4, 0, 4, 1, 1, 0, 0, 2'b00, 2'b00, 1); // lw $4,0($1)
    tbl[13] = mk(1, 1, 4, 1, 4, 1, 8, 1, 0, 1, 0, 2'b00, 2'b00, 1); // add $8,$4,$4 flushed
    tbl[14] = mk(1, 1, 8, 1, 4, 1, 11, 1, 0, 0, 0, 2'b00, 2'b01, 1); // add $11,$8,$4
    tbl[15] = mk(1, 1, 1, 1, 2, 1, 12, 1, 0, 0, 0, 2'b00, 2'b00, 1); // add $12,$1,$2
    tbl[16] = mk(1, 1, 12, 1, 11, 1, 14, 1, 0, 0, 0, 2'b10, 2'b01, 1); // add $14,$12,$11
    tbl[17] = mk(1, 1, 1, 1, 4, 0, 4, 1, 1, 0, 0, 2'b00, 2'b00, 1); // lw $4,0($1)
    tbl[18] = mk(0, 1, 4, 1, 2, 1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 0); // reset during stall
    tbl[19] = mk(1, 1, 4, 1, 2, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 0); // shadow cleared

    t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    drive(t);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d.stall", i), 32'(stall), 32'(tbl[i].es));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.fwd_a", i), 32'(fwd_a_sel), 32'(tbl[i].ea));
      chk($sformatf("v%0d.fwd_b", i), 32'(fwd_b_sel), 32'(tbl[i].eb));
      chk($sformatf("v%0d.cnt", i), 32'(stall_cnt), 32'(tbl[i].ec));
    end

    // Self-dependent load lw $4,0($4) held in ID: stalls every other cycle.
    nstall     = 0;
    prev_stall = 1'b0;
    consec     = 0;
    t = mk(1, 1, 4, 1, 0, 0, 4, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    for (int c = 0; c < 4 * NSAT; c++) begin
      @(negedge clk);
      drive(t);
      #1;
      if (stall === 1'b1) nstall++;
      if (prev_stall && stall === 1'b1) consec++;
      prev_stall = (stall === 1'b1);
      if (nstall == NSAT) break;
      @(posedge clk);
    end
    chk("sat.stall_count", 32'(nstall), 32'(NSAT));
    chk("sat.no_back_to_back", 32'(consec), 32'd0);
    @(posedge clk);
    #1;
    chk("sat.cnt_allones", 32'(stall_cnt), 32'(CW'('1)));

    // Reset clears the saturated counter.
    @(negedge clk);
    t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    drive(t);
    @(posedge clk);
    #1;
    chk("rst.cnt", 32'(stall_cnt), 32'd0);
    chk("rst.fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rst.fwd_b", 32'(fwd_b_sel), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
